// File: rtl/pifo_sched_pkg.sv
// Shared definitions for the PIFO scheduler and buffer blocks.
// Latency: n/a (types, constants and a constant function only).
// Backpressure: n/a.
package pifo_sched_pkg;

  localparam int DEF_PORT_NUM   = 5;
  localparam int DEF_RANK_WIDTH = 16;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Index width for n items. Never returns 0, so a single-queue build
  // still gets a 1-bit index.
  function automatic int log2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/pifo_rank_min_select.sv
// Picks the winning queue: a starved queue first, then the minimum rank, ties broken from rr_ptr.
// Latency: purely combinational.
// Backpressure: none; the caller samples the result when it arbitrates.
module pifo_rank_min_select
  import pifo_sched_pkg::*;
#(
  parameter int PORT_NUM   = DEF_PORT_NUM,
  parameter int RANK_WIDTH = DEF_RANK_WIDTH,
  parameter int IDX_W      = log2(PORT_NUM)
) (
  input  logic [PORT_NUM-1:0]            eligible,
  input  logic [PORT_NUM-1:0]            starved,
  input  logic [PORT_NUM*RANK_WIDTH-1:0] ranks,
  input  logic [IDX_W-1:0]               rr_ptr,
  output logic [IDX_W-1:0]               winner,
  output logic                           winner_vld
);

  logic                  starve_hit;
  logic                  rank_hit;
  logic [IDX_W-1:0]      starve_idx;
  logic [IDX_W-1:0]      rank_idx;
  logic [RANK_WIDTH-1:0] best_rank;
  int                    idx;

  // Scan all queues starting at rr_ptr. Visiting in round-robin order with a
  // strict less-than means the first queue met keeps any tie on rank.
  always_comb begin
    starve_hit = 1'b0;
    rank_hit   = 1'b0;
    starve_idx = '0;
    rank_idx   = '0;
    best_rank  = '0;
    idx        = 0;
    for (int k = 0; k < PORT_NUM; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= PORT_NUM) idx = idx - PORT_NUM;
      if (eligible[idx] && starved[idx] && !starve_hit) begin
        starve_hit = 1'b1;
        starve_idx = IDX_W'(idx);
      end
      if (eligible[idx] && (!rank_hit || ranks[idx*RANK_WIDTH +: RANK_WIDTH] < best_rank)) begin
        rank_hit  = 1'b1;
        rank_idx  = IDX_W'(idx);
        best_rank = ranks[idx*RANK_WIDTH +: RANK_WIDTH];
      end
    end
    winner_vld = starve_hit | rank_hit;
    winner     = starve_hit ? starve_idx : rank_idx;
  end

endmodule

// File: rtl/pifo_deq_scheduler.sv
// Arbitrates per-queue AXIS heads onto one master stream by minimum rank, holding the grant to tlast.
// Latency: 1 cycle from eligibility to first beat; one IDLE bubble between packets.
// Backpressure: m_axis_tready is passed straight through to the granted queue's q_tready only.
module pifo_deq_scheduler
  import pifo_sched_pkg::*;
#(
  parameter  int PORT_NUM        = DEF_PORT_NUM,
  parameter  int DATA_WIDTH      = 256,
  parameter  int SUME_META_WIDTH = 128,
  parameter  int RANK_WIDTH      = DEF_RANK_WIDTH,
  parameter  int STARVE_LIMIT    = 8,
  localparam int IDX_W           = log2(PORT_NUM),
  localparam int KEEP_W          = DATA_WIDTH / 8
) (
  input  logic                              clk_in_0,
  input  logic                              resetn,
  input  logic [PORT_NUM-1:0]               q_tvalid,
  input  logic [PORT_NUM*DATA_WIDTH-1:0]    q_tdata,
  input  logic [PORT_NUM*KEEP_W-1:0]        q_tkeep,
  input  logic [PORT_NUM*SUME_META_WIDTH-1:0] q_tuser,
  input  logic [PORT_NUM-1:0]               q_tlast,
  input  logic [PORT_NUM*RANK_WIDTH-1:0]    q_rank,
  output logic [PORT_NUM-1:0]               q_tready,
  input  logic [PORT_NUM-1:0]               port_mask,
  output logic [DATA_WIDTH-1:0]             m_axis_tdata,
  output logic [KEEP_W-1:0]                 m_axis_tkeep,
  output logic [SUME_META_WIDTH-1:0]        m_axis_tuser,
  output logic                              m_axis_tlast,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic [IDX_W-1:0]                  grant_id,
  output logic                              busy,
  output logic [31:0]                       pkt_sent_cnt
);

  state_t             state;
  state_t             state_nxt;
  logic [IDX_W-1:0]   rr_ptr;
  logic [7:0]         wait_cnt [PORT_NUM];
  logic [PORT_NUM-1:0] eligible;
  logic [PORT_NUM-1:0] starved;
  logic [IDX_W-1:0]   winner;
  logic               winner_vld;
  logic               pkt_end;

  assign eligible = q_tvalid & ~port_mask;
  assign busy     = (state == SEND);

  // A queue counts as starved once it has lost STARVE_LIMIT arbitrations.
  always_comb begin
    starved = '0;
    for (int i = 0; i < PORT_NUM; i++) begin
      starved[i] = (wait_cnt[i] >= 8'(STARVE_LIMIT));
    end
  end

  pifo_rank_min_select #(
    .PORT_NUM   (PORT_NUM),
    .RANK_WIDTH (RANK_WIDTH),
    .IDX_W      (IDX_W)
  ) u_select (
    .eligible   (eligible),
    .starved    (starved),
    .ranks      (q_rank),
    .rr_ptr     (rr_ptr),
    .winner     (winner),
    .winner_vld (winner_vld)
  );

  // State register.
  always_ff @(posedge clk_in_0 or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next state and output mux; outputs stay zero outside SEND.
  always_comb begin
    state_nxt     = state;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tuser  = '0;
    m_axis_tlast  = 1'b0;
    q_tready      = '0;
    pkt_end       = 1'b0;
    case (state)
      IDLE: begin
        if (winner_vld) state_nxt = SEND;
      end
      SEND: begin
        m_axis_tvalid      = q_tvalid[grant_id];
        m_axis_tdata       = q_tdata[grant_id*DATA_WIDTH +: DATA_WIDTH];
        m_axis_tkeep       = q_tkeep[grant_id*KEEP_W +: KEEP_W];
        m_axis_tuser       = q_tuser[grant_id*SUME_META_WIDTH +: SUME_META_WIDTH];
        m_axis_tlast       = q_tlast[grant_id];
        q_tready[grant_id] = m_axis_tready;
        pkt_end            = q_tvalid[grant_id] & m_axis_tready & q_tlast[grant_id];
        if (pkt_end) state_nxt = IDLE;
      end
    endcase
  end

  // Grant capture, wait-counter aging, round-robin advance and packet count.
  always_ff @(posedge clk_in_0 or negedge resetn) begin
    if (!resetn) begin
      grant_id     <= '0;
      rr_ptr       <= '0;
      pkt_sent_cnt <= '0;
      for (int i = 0; i < PORT_NUM; i++) wait_cnt[i] <= '0;
    end else begin
      if (state == IDLE && winner_vld) begin
        grant_id <= winner;
        for (int i = 0; i < PORT_NUM; i++) begin
          if (IDX_W'(i) == winner) begin
            wait_cnt[i] <= '0;
          end else if (eligible[i] && wait_cnt[i] < 8'(STARVE_LIMIT)) begin
            wait_cnt[i] <= wait_cnt[i] + 8'd1;
          end
        end
      end
      if (pkt_end) begin
        rr_ptr <= (grant_id == IDX_W'(PORT_NUM - 1)) ? '0 : grant_id + IDX_W'(1);
        if (pkt_sent_cnt != '1) pkt_sent_cnt <= pkt_sent_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_pifo_deq_scheduler.sv
// Directed bench: per-queue source models feed the scheduler, a scoreboard checks the output stream.
// Latency: n/a.
// Backpressure: m_axis_tready follows a per-test pattern, otherwise held high.
module tb_pifo_deq_scheduler;

  localparam int PN = 5;
  localparam int DW = 256;
  localparam int MW = 128;
  localparam int RW = 16;
  localparam int KW = DW / 8;
  localparam int IW = 3;

  logic                clk_in_0 = 1'b0;
  logic                resetn   = 1'b0;
  logic [PN-1:0]       q_tvalid;
  logic [PN*DW-1:0]    q_tdata;
  logic [PN*KW-1:0]    q_tkeep;
  logic [PN*MW-1:0]    q_tuser;
  logic [PN-1:0]       q_tlast;
  logic [PN*RW-1:0]    q_rank;
  logic [PN-1:0]       q_tready;
  logic [PN-1:0]       port_mask;
  logic [DW-1:0]       m_axis_tdata;
  logic [KW-1:0]       m_axis_tkeep;
  logic [MW-1:0]       m_axis_tuser;
  logic                m_axis_tlast;
  logic                m_axis_tvalid;
  logic                m_axis_tready;
  logic [IW-1:0]       grant_id;
  logic                busy;
  logic [31:0]         pkt_sent_cnt;

  always #5 clk_in_0 = ~clk_in_0;

  pifo_deq_scheduler #(
    .PORT_NUM(PN), .DATA_WIDTH(DW), .SUME_META_WIDTH(MW), .RANK_WIDTH(RW), .STARVE_LIMIT(8)
  ) dut (
    .clk_in_0      (clk_in_0),
    .resetn        (resetn),
    .q_tvalid      (q_tvalid),
    .q_tdata       (q_tdata),
    .q_tkeep       (q_tkeep),
    .q_tuser       (q_tuser),
    .q_tlast       (q_tlast),
    .q_rank        (q_rank),
    .q_tready      (q_tready),
    .port_mask     (port_mask),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .grant_id      (grant_id),
    .busy          (busy),
    .pkt_sent_cnt  (pkt_sent_cnt)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic [MW-1:0] user;
    logic          last;
    logic [RW-1:0] rank;
    int            port;
    int            gap;
  } beat_t;

  beat_t srcq   [PN][$];
  beat_t issued [PN][$];
  beat_t exp_q  [$];
  logic  rdy_pat[$];

  int n_chk      = 0;
  int n_fail     = 0;
  int beats_seen = 0;
  int pkt_id     = 0;
  bit bp_chk     = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  task automatic push_pkt(input int port, input int rank, input int nb);
    beat_t       bt;
    logic [31:0] w;
    for (int b = 0; b < nb; b++) begin
      w       = {8'hA5, 8'(port), 8'(pkt_id), 8'(b)};
      bt.data = {8{w}};
      bt.user = {4{w ^ 32'hFFFF_0000}};
      bt.last = (b == nb - 1);
      bt.keep = bt.last ? 32'h0000_FFFF : 32'hFFFF_FFFF;
      bt.rank = RW'(rank);
      bt.port = port;
      bt.gap  = 0;
      srcq[port].push_back(bt);
      issued[port].push_back(bt);
    end
    pkt_id++;
  endtask

  // Moves the next issued packet of a queue into the scoreboard; gap is the
  // required cycle distance from the previous beat (0 = not checked).
  task automatic expect_next(input int port, input int gap);
    beat_t bt;
    bit    first;
    first = 1'b1;
    while (issued[port].size() > 0) begin
      bt     = issued[port].pop_front();
      bt.gap = first ? gap : 0;
      first  = 1'b0;
      exp_q.push_back(bt);
      if (bt.last) break;
    end
  endtask

  task automatic flush_all();
    for (int i = 0; i < PN; i++) begin
      srcq[i].delete();
      issued[i].delete();
    end
    exp_q.delete();
    rdy_pat.delete();
  endtask

  task automatic wait_drain(input string nm, input int max_cyc);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || busy) && k < max_cyc) begin
      @(negedge clk_in_0);
      k++;
    end
    n_chk++;
    if (k >= max_cyc) begin
      n_fail++;
      $display("FAIL %s_drain: %0d beats still pending after %0d cycles, required 0", nm, exp_q.size(), max_cyc);
      exp_q.delete();
    end
    repeat (2) @(negedge clk_in_0);
  endtask

  task automatic do_reset();
    @(negedge clk_in_0);
    #1 resetn = 1'b0;
    flush_all();
    repeat (2) @(negedge clk_in_0);
    #1 resetn = 1'b1;
  endtask

  // Source model: presents queue heads, pops a head after it was accepted.
  initial begin : driver
    logic [PN-1:0] fire;
    beat_t         tmp;
    fire          = '0;
    q_tvalid      = '0;
    q_tdata       = '0;
    q_tkeep       = '0;
    q_tuser       = '0;
    q_tlast       = '0;
    q_rank        = '0;
    m_axis_tready = 1'b1;
    forever begin
      @(negedge clk_in_0);
      for (int i = 0; i < PN; i++) begin
        if (fire[i] && srcq[i].size() > 0) tmp = srcq[i].pop_front();
      end
      m_axis_tready = (rdy_pat.size() > 0) ? rdy_pat.pop_front() : 1'b1;
      for (int i = 0; i < PN; i++) begin
        if (srcq[i].size() > 0) begin
          q_tvalid[i]             = 1'b1;
          q_tdata[i*DW +: DW]     = srcq[i][0].data;
          q_tkeep[i*KW +: KW]     = srcq[i][0].keep;
          q_tuser[i*MW +: MW]     = srcq[i][0].user;
          q_tlast[i]              = srcq[i][0].last;
          q_rank[i*RW +: RW]      = srcq[i][0].rank;
        end else begin
          q_tvalid[i]             = 1'b0;
          q_tdata[i*DW +: DW]     = '0;
          q_tkeep[i*KW +: KW]     = '0;
          q_tuser[i*MW +: MW]     = '0;
          q_tlast[i]              = 1'b0;
          q_rank[i*RW +: RW]      = '0;
        end
      end
      #3;
      fire = q_tvalid & q_tready;
    end
  end

  // Monitor: pops the scoreboard on every accepted output beat.
  initial begin : monitor
    int    cyc;
    int    last_cyc;
    beat_t e;
    cyc      = 0;
    last_cyc = 0;
    forever begin
      @(negedge clk_in_0);
      #2;
      cyc++;
      if (bp_chk) begin
        chk("bp_q_tready", 64'(q_tready), (busy && m_axis_tready) ? 64'h4 : 64'h0);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        beats_seen++;
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_beat: got beat %h from grant %0d, required no beat", m_axis_tdata[31:0], grant_id);
        end else begin
          e = exp_q.pop_front();
          n_chk++;
          if (m_axis_tdata !== e.data || m_axis_tkeep !== e.keep ||
              m_axis_tuser !== e.user || m_axis_tlast !== e.last) begin
            n_fail++;
            $display("FAIL beat_payload: got word %h keep %h last %b, required word %h keep %h last %b",
                     m_axis_tdata[31:0], m_axis_tkeep, m_axis_tlast, e.data[31:0], e.keep, e.last);
          end
          chk("beat_grant_id", 64'(grant_id), 64'(e.port));
          chk("beat_q_tready", 64'(q_tready), 64'(1 << e.port));
          if (e.gap != 0) chk("pkt_gap_cycles", 64'(cyc - last_cyc), 64'(e.gap));
          last_cyc = cyc;
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int target;
    int k;
    port_mask = '0;
    resetn    = 1'b0;
    repeat (3) @(negedge clk_in_0);
    #1;
    chk("reset_m_tvalid", 64'(m_axis_tvalid), 64'h0);
    chk("reset_q_tready", 64'(q_tready), 64'h0);
    chk("reset_busy", 64'(busy), 64'h0);
    chk("reset_pkt_cnt", 64'(pkt_sent_cnt), 64'h0);
    chk("reset_grant_id", 64'(grant_id), 64'h0);
    chk("reset_m_tdata", m_axis_tdata[63:0], 64'h0);
    chk("reset_m_tlast", 64'(m_axis_tlast), 64'h0);
    resetn = 1'b1;

    // Test 1: minimum rank first.
    do_reset();
    push_pkt(0, 30, 1);
    push_pkt(1, 10, 1);
    push_pkt(2, 20, 1);
    expect_next(1, 0);
    expect_next(2, 2);
    expect_next(0, 2);
    wait_drain("t1", 100);
    chk("t1_pkt_sent_cnt", 64'(pkt_sent_cnt), 64'd3);
    chk("t1_idle_m_tdata", m_axis_tdata[63:0], 64'h0);

    // Test 2: equal ranks rotate from rr_ptr.
    do_reset();
    for (int i = 0; i < PN; i++) begin
      push_pkt(i, 5, 1);
      if (i < 2) push_pkt(i, 5, 1);
    end
    expect_next(0, 0);
    expect_next(1, 2);
    expect_next(2, 2);
    expect_next(3, 2);
    expect_next(4, 2);
    expect_next(0, 2);
    expect_next(1, 2);
    wait_drain("t2", 200);
    chk("t2_pkt_sent_cnt", 64'(pkt_sent_cnt), 64'd7);

    // Test 3: q3 forced after 8 losses, counter cleared, forced again 8 later.
    do_reset();
    for (int i = 0; i < 18; i++) push_pkt(0, 0, 1);
    push_pkt(3, 100, 1);
    push_pkt(3, 100, 1);
    for (int i = 0; i < 8; i++) expect_next(0, (i == 0) ? 0 : 2);
    expect_next(3, 2);
    for (int i = 0; i < 8; i++) expect_next(0, 2);
    expect_next(3, 2);
    expect_next(0, 2);
    expect_next(0, 2);
    wait_drain("t3", 300);
    chk("t3_pkt_sent_cnt", 64'(pkt_sent_cnt), 64'd20);

    // Test 4: backpressure on a 4-beat packet.
    do_reset();
    rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    bp_chk  = 1'b1;
    push_pkt(2, 9, 4);
    expect_next(2, 0);
    wait_drain("t4", 100);
    bp_chk = 1'b0;
    chk("t4_pkt_sent_cnt", 64'(pkt_sent_cnt), 64'd1);

    // Test 5: masked queue is never granted; unmasking mid-packet waits for tlast.
    do_reset();
    port_mask = 5'b00010;
    push_pkt(1, 0, 1);
    repeat (10) @(negedge clk_in_0);
    #1;
    chk("t5_masked_busy", 64'(busy), 64'h0);
    chk("t5_masked_m_tvalid", 64'(m_axis_tvalid), 64'h0);
    chk("t5_masked_q_tready", 64'(q_tready), 64'h0);
    rdy_pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    push_pkt(4, 50, 3);
    expect_next(4, 0);
    expect_next(1, 2);
    repeat (4) @(negedge clk_in_0);
    #1;
    chk("t5_midpkt_busy", 64'(busy), 64'h1);
    chk("t5_midpkt_grant", 64'(grant_id), 64'd4);
    port_mask = '0;
    wait_drain("t5", 100);
    chk("t5_pkt_sent_cnt", 64'(pkt_sent_cnt), 64'd2);

    // Test 6: reset in the middle of a 3-beat packet.
    do_reset();
    push_pkt(3, 1, 1);
    expect_next(3, 0);
    wait_drain("t6a", 100);
    push_pkt(2, 7, 3);
    expect_next(2, 0);
    target = beats_seen + 2;
    k = 0;
    while (beats_seen < target && k < 50) begin
      @(negedge clk_in_0);
      #1;
      k++;
    end
    chk("t6_two_beats_seen", 64'(beats_seen >= target), 64'h1);
    resetn = 1'b0;
    #1;
    chk("t6_rst_m_tvalid", 64'(m_axis_tvalid), 64'h0);
    chk("t6_rst_q_tready", 64'(q_tready), 64'h0);
    chk("t6_rst_pkt_cnt", 64'(pkt_sent_cnt), 64'h0);
    chk("t6_rst_busy", 64'(busy), 64'h0);
    chk("t6_rst_grant_id", 64'(grant_id), 64'h0);
    chk("t6_trunc_left", 64'(exp_q.size()), 64'd1);
    flush_all();
    repeat (2) @(negedge clk_in_0);
    #1 resetn = 1'b1;
    push_pkt(4, 7, 1);
    push_pkt(2, 7, 1);
    expect_next(2, 0);
    expect_next(4, 2);
    wait_drain("t6b", 100);
    chk("t6_pkt_sent_cnt", 64'(pkt_sent_cnt), 64'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pifo_deq_scheduler.md
Name: pifo_deq_scheduler

Overview:
- Output-side scheduler for the PIFO datapath. Arbitrates PORT_NUM per-queue AXI4-Stream heads onto one master AXI4-Stream.
- Picks the eligible queue with the smallest head rank. Ties are broken round-robin, and a starvation guard applies.
- Holds the grant for the whole packet, until tlast.
- Sits between the PIFO queue buffers and the SUME output arbiter/port.

Parameters:
- PORT_NUM, 5: number of queues arbitrated.
- DATA_WIDTH, 256: AXIS data width.
- SUME_META_WIDTH, 128: tuser width.
- RANK_WIDTH, 16: unsigned rank width; smaller value = higher priority.
- STARVE_LIMIT, 8: number of lost arbitrations after which a queue is forced; 1..255.

Ports:
- clk_in_0  in  1  sole clock.
- resetn  in  1  asynchronous, active-low reset.
- q_tvalid  in  PORT_NUM  per-queue head beat valid.
- q_tdata  in  PORT_NUM*DATA_WIDTH  per-queue data; queue i at [i*DATA_WIDTH +: DATA_WIDTH].
- q_tkeep  in  PORT_NUM*DATA_WIDTH/8  per-queue keep.
- q_tuser  in  PORT_NUM*SUME_META_WIDTH  per-queue metadata.
- q_tlast  in  PORT_NUM  per-queue last.
- q_rank  in  PORT_NUM*RANK_WIDTH  head-packet rank; valid whenever the queue's tvalid is high on a first beat.
- q_tready  out  PORT_NUM  per-queue ready.
- port_mask  in  PORT_NUM  1 = queue paused, i.e. not eligible.
- m_axis_tdata / m_axis_tkeep / m_axis_tuser / m_axis_tlast  out  DATA_WIDTH / DATA_WIDTH/8 / SUME_META_WIDTH / 1  scheduled stream.
- m_axis_tvalid  out  1  scheduled stream valid.
- m_axis_tready  in  1  downstream ready.
- grant_id  out  clog2(PORT_NUM)  queue currently granted.
- busy  out  1  high while in SEND.
- pkt_sent_cnt  out  32  packets completed; saturating.

Behaviour:
- Reset (resetn=0, asynchronous):
  - state=IDLE, rr_ptr=0, grant_id=0, all wait counters 0, pkt_sent_cnt=0.
  - m_axis_tvalid=0, q_tready=0, busy=0.
  - m_axis_tdata/tkeep/tuser/tlast driven 0 while in IDLE.
- Eligibility: eligible[i] = q_tvalid[i] & ~port_mask[i].
- IDLE:
  - m_axis_tvalid=0 and q_tready=0.
  - If any queue is eligible, select a winner. The grant is registered; next state is SEND.
  - Arbitration latency: 1 cycle from eligibility to the first beat presented.
- Winner selection, in priority order:
  1. If any eligible queue has wait_cnt >= STARVE_LIMIT, take the first such queue scanning from rr_ptr upward, modulo PORT_NUM.
  2. Otherwise take the eligible queue with the minimum q_rank (unsigned compare).
  3. Equal minimum ranks: take the first one scanning from rr_ptr upward.
- Wait counters, updated at each arbitration event:
  - Winner's wait_cnt cleared to 0.
  - Every other eligible queue increments, saturating at STARVE_LIMIT.
  - Ineligible queues hold their value.
- SEND:
  - m_axis_* = q_*[grant_id], combinational mux.
  - q_tready[grant_id] = m_axis_tready; all other q_tready = 0.
  - port_mask changes are ignored until packet end.
  - On the beat where q_tvalid[g] & m_axis_tready & q_tlast[g]: state goes to IDLE, rr_ptr = (grant_id+1) mod PORT_NUM, pkt_sent_cnt increments (saturating at 0xFFFFFFFF).
  - Exactly one IDLE bubble cycle separates packets.
- Granted queue drops tvalid mid-packet: m_axis_tvalid follows it low. The grant is held with no timeout.
- Single-beat packet (tlast on the first beat): valid; returns to IDLE after that beat.
- Reset mid-packet: the output is truncated with no tlast. Downstream must tolerate this; no recovery logic here.
- PORT_NUM=1: rr_ptr stays 0; the block degenerates to a pass-through with a 1-cycle bubble per packet.
- grant_id holds its last value in IDLE.

Decomposition:
- Shared package pifo_sched_pkg holds:
  - state encodings: IDLE=1'b0, SEND=1'b1;
  - the log2 function;
  - defaults for PORT_NUM and RANK_WIDTH, shared with the PIFO buffer blocks.
- Sub-module pifo_rank_min_select: purely combinational.
  - Inputs: eligible, starved, ranks, rr_ptr.
  - Outputs: winner index and winner-valid.
  - Instantiated once.

Test Plan:
1. Ranks {q0=30, q1=10, q2=20}, all valid, single-beat packets, m_axis_tready=1. Required: output order q1, q2, q0; pkt_sent_cnt=3; one idle cycle between packets.
2. Ties: q0..q4 all rank 5 with continuous packets. Required: grants 0,1,2,3,4,0 (round-robin from rr_ptr=0).
3. Starvation: q0 rank 0 continuously refilled, q3 rank 100 valid, STARVE_LIMIT=8. Required: q3 granted on the 9th arbitration; its wait_cnt then clears.
4. Backpressure: q2 4-beat packet; m_axis_tready toggles 1,0,0,1,1,0,1. Required: all 4 beats delivered in order; q_tready[2] mirrors m_axis_tready; no other q_tready asserted.
5. port_mask[1] set while q1 has rank 0: q1 is never granted. Clearing the mask mid-packet of q4 has no effect until q4's tlast; q1 is granted next.
6. resetn pulsed low during beat 2 of a 3-beat packet. Required: immediately m_axis_tvalid=0, q_tready=0, pkt_sent_cnt=0; after release, a fresh arbitration starts from rr_ptr=0.
